conv3x3_prog_pipe: RTL and testbench

Programmable, fully pipelined 3x3 convolution with ReLU for multi-channel pixels. It sits in the filter stage of the image pipeline, between the 3x3 window generator and the output formatter. Four kernel slots are held in a runtime-writable coefficient bank, and each slot has its own bias and rounding right-shift. Throughput is one window per cycle with a fixed 3-cycle latency, and valid/ready backpressure is honoured end to end.

---
 rtl/conv3x3_prog_pipe.sv | 177 +++++++++++++++++
 tb/tb_conv3x3_prog_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_prog_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : conv3x3_prog_pipe
//  Brief    : Programmable 3x3 multi-channel convolution with bias, rounding
//             shift and ReLU/saturation; valid/ready pipelined, 4 kernel slots.
//  Revision : 1.0  initial release
// ============================================================================
module conv3x3_prog_pipe #(
    parameter int CH     = 3,
    parameter int PIX_W  = 8,
    parameter int COEFFW = 8,
    parameter int ACCW   = 24
) (
    input  logic                    iClk,
    input  logic                    iRst,
    input  logic [1:0]              mode,
    input  logic [9*CH*PIX_W-1:0]   i_data,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic [CH*PIX_W-1:0]     o_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    input  logic                    wr_en,
    input  logic [5:0]              wr_addr,
    input  logic [15:0]             wr_data
);

    localparam int                     c_PROD_W  = PIX_W + COEFFW + 1;
    localparam logic signed [ACCW-1:0] c_ONE     = ACCW'(1);
    localparam logic signed [ACCW-1:0] c_PIX_MAX = ACCW'((1 << PIX_W) - 1);

    // Coefficient bank
    logic signed [COEFFW-1:0] r_coef  [4][9];
    logic        [3:0]        r_shift [4];
    logic signed [15:0]       r_bias  [4];

    // Pipeline registers
    logic                       r_v1, r_v2, r_v3;
    logic signed [c_PROD_W-1:0] r_prod  [9][CH];
    logic        [3:0]          r_shift1, r_shift2;
    logic signed [15:0]         r_bias1;
    logic signed [ACCW-1:0]     r_sum2  [CH];
    logic [CH*PIX_W-1:0]        r_pix3;

    logic                       w_adv_out, w_adv3, w_adv2, w_adv1;
    logic signed [c_PROD_W-1:0] w_prod  [9][CH];
    logic signed [ACCW-1:0]     w_sum   [CH];
    logic signed [ACCW-1:0]     w_norm  [CH];
    logic [CH*PIX_W-1:0]        w_pix3;

    function automatic logic signed [COEFFW-1:0] f_default_coef(input int slot, input int idx);
        int v;
        v = 0;
        case (slot)
            0:       v = (idx == 4) ? 1 : 0;
            1:       v = (idx == 4) ? 5 : ((idx == 1 || idx == 3 || idx == 5 || idx == 7) ? -1 : 0);
            2:       v = (idx == 4) ? 9 : -1;
            default: begin
                case (idx)
                    0:       v = -2;
                    1:       v = -1;
                    3:       v = -1;
                    4:       v = 1;
                    5:       v = 1;
                    7:       v = 1;
                    8:       v = 2;
                    default: v = 0;
                endcase
            end
        endcase
        return v[COEFFW-1:0];
    endfunction

    // Each stage moves when the stage after it has room
    assign w_adv_out = !o_valid || o_ready;
    assign w_adv3    = !r_v3 || w_adv_out;
    assign w_adv2    = !r_v2 || w_adv3;
    assign w_adv1    = !r_v1 || w_adv2;
    assign i_ready   = w_adv1;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int s = 0; s < 4; s++) begin
                for (int w = 0; w < 9; w++) begin
                    r_coef[s][w] <= f_default_coef(s, w);
                end
                r_shift[s] <= '0;
                r_bias[s]  <= '0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < 9; w++) begin
                if (wr_addr[3:0] == 4'(w)) begin
                    r_coef[wr_addr[5:4]][w] <= wr_data[COEFFW-1:0];
                end
            end
            if (wr_addr[3:0] == 4'd9) begin
                r_shift[wr_addr[5:4]] <= wr_data[3:0];
            end
            if (wr_addr[3:0] == 4'd10) begin
                r_bias[wr_addr[5:4]] <= wr_data;
            end
        end
    end

    // Stage 1: products against the slot selected at accept time
    always_comb begin
        for (int w = 0; w < 9; w++) begin
            for (int c = 0; c < CH; c++) begin
                w_prod[w][c] = $signed({{(c_PROD_W-COEFFW){r_coef[mode][w][COEFFW-1]}}, r_coef[mode][w]})
                             * $signed({{(COEFFW+1){1'b0}}, i_data[(w*CH+c)*PIX_W +: PIX_W]});
            end
        end
    end

    // Stage 2: tap sum plus bias
    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_sum[c] = {{(ACCW-16){r_bias1[15]}}, r_bias1};
            for (int w = 0; w < 9; w++) begin
                w_sum[c] = w_sum[c] + {{(ACCW-c_PROD_W){r_prod[w][c][c_PROD_W-1]}}, r_prod[w][c]};
            end
        end
    end

    // Stage 3: round-half-up shift, then ReLU and saturate
    always_comb begin
        w_pix3 = '0;
        for (int c = 0; c < CH; c++) begin
            if (r_shift2 != 4'd0) begin
                w_norm[c] = (r_sum2[c] + (c_ONE << (r_shift2 - 4'd1))) >>> r_shift2;
            end else begin
                w_norm[c] = r_sum2[c];
            end
            if (w_norm[c] <= 0) begin
                w_pix3[c*PIX_W +: PIX_W] = '0;
            end else if (w_norm[c] >= c_PIX_MAX) begin
                w_pix3[c*PIX_W +: PIX_W] = '1;
            end else begin
                w_pix3[c*PIX_W +: PIX_W] = w_norm[c][PIX_W-1:0];
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            if (w_adv1)    r_v1    <= i_valid;
            if (w_adv2)    r_v2    <= r_v1;
            if (w_adv3)    r_v3    <= r_v2;
            if (w_adv_out) o_valid <= r_v3;
            if (w_adv_out && r_v3) o_data <= r_pix3;
        end
    end

    // Datapath registers only load when their stage advances with valid data
    always_ff @(posedge iClk) begin
        if (w_adv1 && i_valid) begin
            r_prod   <= w_prod;
            r_shift1 <= r_shift[mode];
            r_bias1  <= r_bias[mode];
        end
        if (w_adv2 && r_v1) begin
            r_sum2   <= w_sum;
            r_shift2 <= r_shift1;
        end
        if (w_adv3 && r_v2) begin
            r_pix3 <= w_pix3;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_prog_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv3x3_prog_pipe
//  Brief    : Directed self-checking bench for conv3x3_prog_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv3x3_prog_pipe;

    localparam int CH    = 3;
    localparam int PIX_W = 8;

    logic                  iClk = 1'b0;
    logic                  iRst = 1'b1;
    logic [1:0]            mode = '0;
    logic [9*CH*PIX_W-1:0] i_data = '0;
    logic                  i_valid = 1'b0;
    logic                  i_ready;
    logic [CH*PIX_W-1:0]   o_data;
    logic                  o_valid;
    logic                  o_ready = 1'b1;
    logic                  wr_en = 1'b0;
    logic [5:0]            wr_addr = '0;
    logic [15:0]           wr_data = '0;

    int checks   = 0;
    int failures = 0;

    // Handshake snapshot taken just before each rising edge
    logic                acc_now;
    logic                xfer_now;
    logic [CH*PIX_W-1:0] xfer_data;

    conv3x3_prog_pipe #(.CH(CH), .PIX_W(PIX_W), .COEFFW(8), .ACCW(24)) dut (
        .iClk(iClk), .iRst(iRst), .mode(mode), .i_data(i_data), .i_valid(i_valid),
        .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 iClk = ~iClk;

    function automatic logic [9*CH*PIX_W-1:0] mk_win(input logic [7:0] ctr, input logic [7:0] oth);
        logic [9*CH*PIX_W-1:0] d;
        d = '0;
        for (int w = 0; w < 9; w++)
            for (int c = 0; c < CH; c++)
                d[(w*CH+c)*PIX_W +: PIX_W] = (w == 4) ? ctr : oth;
        return d;
    endfunction

    function automatic logic [7:0] bp_pix(input int j, input int c);
        return 8'(20*j + 7*c + 5);
    endfunction

    function automatic logic [9*CH*PIX_W-1:0] mk_bp_win(input int j);
        logic [9*CH*PIX_W-1:0] d;
        d = '1;
        for (int c = 0; c < CH; c++)
            d[(4*CH+c)*PIX_W +: PIX_W] = bp_pix(j, c);
        return d;
    endfunction

    function automatic logic [CH*PIX_W-1:0] bp_exp(input int j);
        return {bp_pix(j, 2), bp_pix(j, 1), bp_pix(j, 0)};
    endfunction

    task automatic cycle();
        @(negedge iClk);
        acc_now   = i_valid && i_ready;
        xfer_now  = o_valid && o_ready;
        xfer_data = o_data;
        @(posedge iClk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        wr_en   = 1'b0;
        o_ready = 1'b1;
        iRst    = 1'b1;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRst = 1'b0;
        @(posedge iClk);
        #1;
    endtask

    task automatic write_bank(input logic [1:0] slot, input logic [3:0] idx, input logic [15:0] data);
        wr_en   = 1'b1;
        wr_addr = {slot, idx};
        wr_data = data;
        cycle();
        wr_en = 1'b0;
    endtask

    // Accepts one window and waits for its beat; no comparisons here
    task automatic send_and_wait(input logic [1:0] m, input logic [9*CH*PIX_W-1:0] win,
                                 output logic [CH*PIX_W-1:0] got, output int lat, output bit tmo);
        int k;
        o_ready = 1'b1;
        mode    = m;
        i_data  = win;
        i_valid = 1'b1;
        tmo     = 1'b1;
        got     = '0;
        lat     = -1;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (acc_now) begin
                tmo = 1'b0;
                break;
            end
        end
        i_valid = 1'b0;
        if (!tmo) begin
            tmo = 1'b1;
            for (k = 1; k <= 12; k++) begin
                cycle();
                if (xfer_now) begin
                    tmo = 1'b0;
                    got = xfer_data;
                    lat = k - 1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_o_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_data !== '0) begin failures++; $display("FAIL reset_o_data: got %h expected 000000", o_data); end
        checks++;
        if (i_ready !== 1'b1) begin failures++; $display("FAIL reset_i_ready: got %b expected 1", i_ready); end
    endtask

    task automatic test_kernels();
        logic [CH*PIX_W-1:0] got;
        int lat;
        bit tmo;
        logic [1:0]  m_tab   [5] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0]  ctr_tab [5] = '{8'd100, 8'd100, 8'd200, 8'd10, 8'd100};
        logic [7:0]  oth_tab [5] = '{8'd100, 8'd100, 8'd50, 8'd200, 8'd100};
        logic [7:0]  exp_tab [5] = '{8'd100, 8'd100, 8'd255, 8'd0, 8'd100};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_and_wait(m_tab[i], mk_win(ctr_tab[i], oth_tab[i]), got, lat, tmo);
            checks++;
            if (tmo || lat != 3) begin
                failures++;
                $display("FAIL kernel%0d_latency: got %0d expected 3 (timeout=%0b)", i, lat, tmo);
            end
            checks++;
            if (got !== {CH{exp_tab[i]}}) begin
                failures++;
                $display("FAIL kernel%0d_data: got %h expected %h", i, got, {CH{exp_tab[i]}});
            end
        end
    endtask

    task automatic test_bank_write();
        logic [CH*PIX_W-1:0] got;
        int lat;
        bit tmo;
        do_reset();
        for (int w = 0; w < 9; w++) write_bank(2'd0, 4'(w), 16'd1);
        write_bank(2'd0, 4'd9, 16'd3);
        send_and_wait(2'd0, mk_win(8'd100, 8'd100), got, lat, tmo);
        checks++;
        if (tmo || got !== {CH{8'd113}}) begin
            failures++; $display("FAIL write_shift_113: got %h expected %h", got, {CH{8'd113}});
        end
        send_and_wait(2'd0, mk_win(8'd4, 8'd4), got, lat, tmo);
        checks++;
        if (tmo || got !== {CH{8'd5}}) begin
            failures++; $display("FAIL write_shift_round: got %h expected %h", got, {CH{8'd5}});
        end
        write_bank(2'd3, 4'd10, 16'd128);
        write_bank(2'd3, 4'd11, 16'hFFFF);
        send_and_wait(2'd3, mk_win(8'd100, 8'd100), got, lat, tmo);
        checks++;
        if (tmo || got !== {CH{8'd228}}) begin
            failures++; $display("FAIL write_bias_228: got %h expected %h", got, {CH{8'd228}});
        end
        write_bank(2'd2, 4'd10, 16'hFF9C);
        send_and_wait(2'd2, mk_win(8'd150, 8'd150), got, lat, tmo);
        checks++;
        if (tmo || got !== {CH{8'd50}}) begin
            failures++; $display("FAIL write_neg_bias: got %h expected %h", got, {CH{8'd50}});
        end
    endtask

    task automatic test_write_during_traffic();
        logic [7:0] exp_tab [4] = '{8'd50, 8'd50, 8'd100, 8'd100};
        int n_acc = 0;
        int got_n = 0;
        do_reset();
        mode   = 2'd0;
        i_data = mk_win(8'd50, 8'd50);
        for (int cyc = 0; cyc < 30 && got_n < 4; cyc++) begin
            i_valid = (n_acc < 4);
            wr_en   = (n_acc == 1);
            wr_addr = {2'd0, 4'd4};
            wr_data = 16'd2;
            cycle();
            if (acc_now) n_acc++;
            if (xfer_now) begin
                checks++;
                if (xfer_data !== {CH{exp_tab[got_n]}}) begin
                    failures++;
                    $display("FAIL traffic_beat%0d: got %h expected %h", got_n, xfer_data, {CH{exp_tab[got_n]}});
                end
                got_n++;
            end
        end
        i_valid = 1'b0;
        wr_en   = 1'b0;
        checks++;
        if (got_n != 4) begin failures++; $display("FAIL traffic_count: got %0d expected 4", got_n); end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int got_n = 0;
        int last  = 0;
        do_reset();
        mode = 2'd0;
        for (int cyc = 0; cyc < 60 && got_n < 8; cyc++) begin
            o_ready = !(cyc >= 2 && cyc <= 8);
            i_valid = (n_acc < 8);
            i_data  = mk_bp_win(n_acc);
            cycle();
            if (cyc >= 4 && cyc <= 8) begin
                checks++;
                if (i_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== bp_exp(0)) begin
                    failures++;
                    $display("FAIL stall_hold_c%0d: got i_ready=%b o_valid=%b o_data=%h expected 0 1 %h",
                             cyc, i_ready, o_valid, o_data, bp_exp(0));
                end
            end
            if (acc_now) n_acc++;
            if (cyc == 8) begin
                checks++;
                if (n_acc != 4) begin failures++; $display("FAIL stall_accepts: got %0d expected 4", n_acc); end
            end
            if (xfer_now) begin
                checks++;
                if (xfer_data !== bp_exp(got_n) || (got_n > 0 && cyc != last + 1)) begin
                    failures++;
                    $display("FAIL bp_beat%0d: got %h at cycle %0d expected %h at cycle %0d",
                             got_n, xfer_data, cyc, bp_exp(got_n), last + 1);
                end
                last = cyc;
                got_n++;
            end
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        checks++;
        if (got_n != 8) begin failures++; $display("FAIL bp_count: got %0d expected 8", got_n); end
    endtask

    task automatic test_reset_mid_stream();
        logic [CH*PIX_W-1:0] got;
        int lat;
        bit tmo;
        int n_acc = 0;
        int beats = 0;
        do_reset();
        write_bank(2'd1, 4'd4, 16'd1);
        mode   = 2'd2;
        i_data = mk_win(8'd77, 8'd77);
        for (int cyc = 0; cyc < 10 && n_acc < 3; cyc++) begin
            i_valid = 1'b1;
            cycle();
            if (acc_now) n_acc++;
        end
        i_valid = 1'b0;
        cycle();
        #2;
        iRst = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_data !== '0) begin
            failures++; $display("FAIL midrst_async: got o_valid=%b o_data=%h expected 0 000000", o_valid, o_data);
        end
        @(negedge iClk);
        iRst = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            cycle();
            if (o_valid) beats++;
        end
        checks++;
        if (beats != 0) begin failures++; $display("FAIL midrst_stale: got %0d beats expected 0", beats); end
        send_and_wait(2'd1, mk_win(8'd100, 8'd100), got, lat, tmo);
        checks++;
        if (tmo || got !== {CH{8'd100}}) begin
            failures++; $display("FAIL midrst_defaults: got %h expected %h", got, {CH{8'd100}});
        end
    endtask

    initial begin
        test_reset();
        test_kernels();
        test_bank_write();
        test_write_during_traffic();
        test_back_to_back();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
